// File: rtl/spi_xq_pkg.sv
// Shared types and constants for the SPI transfer queue sequencer.
package spi_xq_pkg;

    typedef enum logic [2:0] {
        XQ_IDLE     = 3'd0,
        XQ_LOAD     = 3'd1,
        XQ_START    = 3'd2,
        XQ_WAIT_TIP = 3'd3,
        XQ_XFER     = 3'd4,
        XQ_CAPTURE  = 3'd5
    } xq_state_t;

    localparam logic [3:0] LATCH_WORD0 = 4'b0001;
    localparam logic [3:0] BSEL_ALL    = 4'hF;
    localparam int         WDOG_LIMIT  = 8;

endpackage

// File: rtl/spi_xq_fifo.sv
// Synchronous circular-buffer queue with show-ahead head word and occupancy count.
module spi_xq_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/spi_xfer_queue.sv
// TX/RX queued transfer sequencer driving the SPI shift stage.
// Optional tip watchdog enabled by defining SPI_XQ_WATCHDOG_EN.
module spi_xfer_queue
    import spi_xq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   tx_wr,
    input  logic [DATA_W-1:0]      tx_data,
    output logic                   tx_full,
    output logic [$clog2(DEPTH):0] tx_level,
    input  logic                   rx_rd,
    output logic [DATA_W-1:0]      rx_data,
    output logic                   rx_empty,
    output logic [$clog2(DEPTH):0] rx_level,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic                   err,
    output logic [3:0]             latch,
    output logic [3:0]             byte_sel,
    output logic [31:0]            p_in,
    output logic                   go,
    input  logic                   tip,
    input  logic [DATA_W-1:0]      p_out
);

    xq_state_t         state_reg;
    xq_state_t         state_next;
    logic [DATA_W-1:0] tx_head;
    logic              tx_empty;
    logic              rx_full;
    logic              start_ok;
    logic              tx_pop;
    logic              rx_push;
    logic              wd_expire;
    logic [31:0]       head_ext;
    logic [31:0]       p_in_reg;
    logic              ovf_reg;

    spi_xq_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_wr), .pop(tx_pop), .din(tx_data),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    spi_xq_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_rd), .din(p_out),
        .dout(rx_data), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    // RX space is reserved here, so CAPTURE can always push.
    assign start_ok = enable && !tx_empty && !rx_full;
    assign tx_pop   = (state_reg == XQ_IDLE) && start_ok;
    assign rx_push  = (state_reg == XQ_CAPTURE);

    always_comb begin
        head_ext               = '0;
        head_ext[DATA_W-1:0]   = tx_head;
    end

`ifdef SPI_XQ_WATCHDOG_EN
    logic [3:0] wd_cnt_reg;
    logic       err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            wd_cnt_reg <= (state_reg == XQ_WAIT_TIP) ? wd_cnt_reg + 4'd1 : 4'd0;
            if (wd_expire) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign wd_expire = (state_reg == XQ_WAIT_TIP) && !tip && (wd_cnt_reg == 4'(WDOG_LIMIT - 1));
    assign err       = err_reg;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= XQ_IDLE;
            p_in_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (tx_pop) begin
                p_in_reg <= head_ext;
            end
            if (tx_wr && tx_full) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            XQ_IDLE:     if (start_ok) state_next = XQ_LOAD;
            XQ_LOAD:     state_next = XQ_START;
            XQ_START:    state_next = XQ_WAIT_TIP;
            XQ_WAIT_TIP: begin
                if (tip) begin
                    state_next = XQ_XFER;
                end else if (wd_expire) begin
                    state_next = XQ_IDLE;
                end
            end
            XQ_XFER:     if (!tip) state_next = XQ_CAPTURE;
            XQ_CAPTURE:  state_next = XQ_IDLE;
            default:     state_next = XQ_IDLE;
        endcase
    end

    always_comb begin
        latch    = '0;
        byte_sel = '0;
        go       = 1'b0;
        done     = 1'b0;
        busy     = (state_reg != XQ_IDLE);
        case (state_reg)
            XQ_LOAD: begin
                latch    = LATCH_WORD0;
                byte_sel = BSEL_ALL;
            end
            XQ_START:   go   = 1'b1;
            XQ_CAPTURE: done = 1'b1;
            default: ;
        endcase
    end

    assign p_in = p_in_reg;
    assign ovf  = ovf_reg;

endmodule

// File: doc/spi_xfer_queue.md
# spi_xfer_queue

Transfer sequencer with TX/RX word queues between the SPI register interface and the SPI shift stage. Software pushes TX words. The block loads each word into the shift register with latch/byte_sel/p_in and starts the transfer with a single-cycle go. When tip falls, it captures the parallel result into an RX queue. This lets several back-to-back characters run without software handling each one.

## Interface
- DATA_W, 32: character/queue word width; matches SPI_MAX_CHAR, max 32.
- DEPTH, 4: entries per queue; power of two, ≥2.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  level; permits new transfers to start.
- tx_wr  in  1  push strobe.
- tx_data  in  DATA_W  push word.
- tx_full  out  1  TX queue full.
- tx_level  out  $clog2(DEPTH)+1  TX occupancy.
- rx_rd  in  1  pop strobe.
- rx_data  out  DATA_W  RX head word (show-ahead).
- rx_empty  out  1  RX queue empty.
- rx_level  out  $clog2(DEPTH)+1  RX occupancy.
- busy  out  1  FSM not IDLE.
- done  out  1  one-cycle pulse per captured word.
- ovf  out  1  sticky: push while full; cleared only by rst.
- err  out  1  sticky watchdog error (see Configuration).
- latch  out  4  to shift stage; only bit 0 ever used.
- byte_sel  out  4  to shift stage.
- p_in  out  32  to shift stage; zero-extended head word.
- go  out  1  to shift stage.
- tip  in  1  from shift stage.
- p_out  in  DATA_W  from shift stage.

## Operation
- Queues: synchronous circular buffers with read/write pointers plus count.
  - Push is accepted iff the pre-cycle state is !full.
  - A push to a full queue is dropped and sets ovf (TX only).
  - Pop from an empty queue is ignored.
  - Simultaneous push and pop are both performed and the level is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LOAD, START, WAIT_TIP, XFER, CAPTURE.
  - IDLE→LOAD when enable && tx_level≠0 && rx_level<DEPTH. The TX pop happens on this transition.
  - LOAD: latch=4'b0001, byte_sel=4'hF, p_in=popped word (registered copy). Always →START.
  - START: go=1 for exactly this cycle. Always →WAIT_TIP.
  - WAIT_TIP: →XFER when tip=1.
  - XFER: →CAPTURE when tip=0.
  - CAPTURE: push p_out into RX, pulse done. Always →IDLE.
- RX has room by construction, because the reservation is checked at IDLE exit and no other source pushes RX.
- Deasserting enable mid-transfer does not abort; the current word completes and the FSM then holds in IDLE.
- A full RX queue stalls in IDLE; no TX word is consumed.
- Outside LOAD: latch=0, byte_sel=0, p_in holds its last value. go=0 outside START.

## Timing
- Reset values:
  - All outputs 0, except p_in=0 and tx_full=0, rx_empty=1.
  - Queues empty, FSM in IDLE.
- Reset mid-transfer returns to IDLE immediately and go drops. The in-flight word is lost, and the shift stage is reset by the same rst.
- Minimum overhead from IDLE to go is 2 cycles: IDLE→LOAD, then START.
- done and the RX push occur 1 cycle after tip is sampled low.
- From CAPTURE, the next go comes no earlier than 3 cycles later: IDLE, LOAD, START.
- tx_level/rx_level/flags update on the clock edge after the strobe.
- rx_data is valid combinationally whenever !rx_empty.

## Configuration
- SPI_XQ_WATCHDOG_EN defined:
  - A 4-bit counter runs in WAIT_TIP.
  - If tip is not seen within 8 cycles of entering WAIT_TIP, set err and return to IDLE. The word is dropped, with no RX push and no done.
- Without the macro:
  - WAIT_TIP waits indefinitely.
  - err is tied 0.

## Structure
- Package spi_xq_pkg holds:
  - state enum type xq_state_t.
  - LATCH_WORD0=4'b0001, BSEL_ALL=4'hF.
  - WDOG_LIMIT=8.
- Sub-module spi_xq_fifo (params DATA_W, DEPTH; ports push, pop, din, dout, full, empty, level) is instantiated twice, for TX and RX.

## Test plan
- Push 0xA5 with enable=1 and a shift model that raises tip 1 cycle after go, holds it 10 cycles and returns p_out=0x5A:
  - LOAD shows p_in=0xA5, latch=1, byte_sel=F.
  - go is a single cycle.
  - done fires 1 cycle after tip falls.
  - rx_data=0x5A, rx_level=1.
- Push 4 words with DEPTH=4, then a 5th:
  - tx_full=1 and ovf=1.
  - Four transfers run back-to-back in order, and RX holds all four in order.
- Fill RX (4 words, no rx_rd), then push 1 more TX word:
  - The FSM stays in IDLE and tx_level stays at 1.
  - One rx_rd starts the transfer within 2 cycles.
- Drop enable while in XFER:
  - The transfer completes with done=1.
  - The remaining queued TX words are not started until enable returns.
- Assert rst while in XFER:
  - All outputs return to reset values the same cycle, levels=0.
- With SPI_XQ_WATCHDOG_EN defined, hold tip=0 after go:
  - err=1 after 8 cycles, FSM returns to IDLE, no done, rx_level unchanged.
